// File: rtl/fp_result_drain.sv
// fp_result_drain
// Buffers 16-bit FP16 results from the final add stage in a small circular
// FIFO and streams each entry out as two bytes, low byte first, over a
// valid/ready interface. Results arriving while the buffer is full are
// dropped and counted in a saturating counter.
module fp_result_drain #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] s_in,
    input  logic        s_save,
    input  logic        out_ready,
    input  logic        clr_drop,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    output logic        full,
    output logic        empty,
    output logic [3:0]  level,
    output logic [7:0]  drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [3:0]    r_level;
    logic          r_hi;
    logic [7:0]    r_dropCnt;

    logic          w_full;
    logic          w_empty;
    logic          w_byteXfer;
    logic          w_entryDone;
    logic          w_push;
    logic          w_drop;
    logic [15:0]   w_head;

    // Status flags, handshake qualifiers and push/drop decisions.
    // A push into a full FIFO is still accepted when the same edge retires
    // the head entry, since that frees the slot being written.
    always_comb begin
        w_full      = (r_level == 4'(DEPTH));
        w_empty     = (r_level == 4'd0);
        w_byteXfer  = !w_empty && out_ready;
        w_entryDone = w_byteXfer && r_hi;
        w_push      = s_save && (!w_full || w_entryDone);
        w_drop      = s_save && w_full && !w_entryDone;
        w_head      = r_mem[r_rp];
    end

    // Entry storage; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= s_in;
        end
    end

    // Pointers, occupancy and byte phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= 4'd0;
            r_hi    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_byteXfer) begin
                r_hi <= !r_hi;
            end
            if (w_entryDone) begin
                r_rp <= r_rp + 1'b1;
            end
            r_level <= r_level + {3'b000, w_push} - {3'b000, w_entryDone};
        end
    end

    // Saturating drop counter; a clear wins over a same-cycle drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dropCnt <= 8'h00;
        end else if (clr_drop) begin
            r_dropCnt <= 8'h00;
        end else if (w_drop && (r_dropCnt != 8'hFF)) begin
            r_dropCnt <= r_dropCnt + 8'h01;
        end
    end

    // Output byte selected purely from registered head entry and phase.
    always_comb begin
        out_valid = !w_empty;
        out_byte  = 8'h00;
        if (!w_empty) begin
            out_byte = r_hi ? w_head[15:8] : w_head[7:0];
        end
        full     = w_full;
        empty    = w_empty;
        level    = r_level;
        drop_cnt = r_dropCnt;
    end

endmodule
